mem2icb_bridge: RTL and testbench

Registered bridge between the PicoRV32 native memory bus and one ICB slave such as the UART or QSPI controller. It sits between the chip address decoder and the peripheral, and replaces the tie-off where mem_ready is driven straight from mem_valid. It honours icb_cmd_ready and icb_rsp_valid, so slow or back-pressuring peripherals complete correctly. A timeout guard reports an error instead of letting a dead slave hang the CPU.

---
 rtl/mem2icb_pkg.sv | 14 +
 rtl/mem2icb_if.sv | 27 ++
 rtl/mem2icb_bridge.sv | 138 +++++++++++++
 tb/tb_mem2icb_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem2icb_pkg.sv
// Shared types and constants for the PicoRV32-native-bus to ICB bridge.
package mem2icb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_RSP    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ORPHAN = 3'd4
    } state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem2icb_if.sv
// ICB command/response channel between the bridge (master) and one peripheral (slave).
interface mem2icb_if;

    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

endinterface

// File: rtl/mem2icb_bridge.sv
// Registered PicoRV32 native-bus to ICB bridge with a timeout guard and orphan-response drain.
module mem2icb_bridge
    import mem2icb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    mem2icb_if.master   icb,
    output logic        err_pulse,
    output logic [31:0] err_addr
);

    localparam int          TW      = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);
    // With the guard disabled the timer just parks at all-ones.
    localparam logic [TW-1:0] T_SAT   = (TIMEOUT_CYCLES == 0) ? {TW{1'b1}} : T_LIMIT;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic [3:0]    wstrb_q;
    logic [TW-1:0] timer_q;
    logic          err_q, orphan_q;

    logic capture, timer_clr, rsp_take, fail, orphan_set, orphan_clr, expired;

    assign expired = (TIMEOUT_CYCLES != 0) && (timer_q == T_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        timer_clr  = 1'b0;
        rsp_take   = 1'b0;
        fail       = 1'b0;
        orphan_set = 1'b0;
        orphan_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: if (mem_valid) begin
                capture   = 1'b1;
                timer_clr = 1'b1;
                state_d   = ST_CMD;
            end
            // A handshake in the expiry cycle still counts; only a silent slave is abandoned.
            ST_CMD: if (icb.icb_cmd_ready) begin
                state_d = ST_RSP;
            end else if (expired) begin
                fail    = 1'b1;
                state_d = ST_DONE;
            end
            ST_RSP: if (icb.icb_rsp_valid) begin
                rsp_take = 1'b1;
                state_d  = ST_DONE;
            end else if (expired) begin
                fail       = 1'b1;
                orphan_set = 1'b1;
                state_d    = ST_DONE;
            end
            ST_DONE: if (orphan_q) begin
                timer_clr = 1'b1;
                state_d   = ST_ORPHAN;
            end else begin
                state_d = ST_IDLE;
            end
            ST_ORPHAN: if (icb.icb_rsp_valid || expired) begin
                orphan_clr = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            orphan_q <= 1'b0;
            timer_q  <= '0;
            err_addr <= '0;
        end else begin
            if (capture) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end

            if (timer_clr) begin
                timer_q <= '0;
            end else if ((state_q == ST_CMD || state_q == ST_RSP || state_q == ST_ORPHAN)
                         && timer_q != T_SAT) begin
                timer_q <= timer_q + TW'(1);
            end

            // Write responses carry no data for the CPU; only errors override that.
            if (rsp_take) begin
                err_q   <= icb.icb_rsp_err;
                rdata_q <= icb.icb_rsp_err ? ERR_RDATA
                         : (wstrb_q == 4'b0000) ? icb.icb_rsp_rdata : 32'h0;
                if (icb.icb_rsp_err) err_addr <= addr_q;
            end else if (fail) begin
                err_q    <= 1'b1;
                rdata_q  <= ERR_RDATA;
                err_addr <= addr_q;
            end

            if (orphan_set)      orphan_q <= 1'b1;
            else if (orphan_clr) orphan_q <= 1'b0;
        end
    end

    assign mem_ready = (state_q == ST_DONE);
    assign mem_rdata = mem_ready ? rdata_q : 32'h0;
    assign err_pulse = mem_ready & err_q;

    assign icb.icb_cmd_valid = (state_q == ST_CMD);
    assign icb.icb_rsp_ready = (state_q == ST_RSP) || (state_q == ST_ORPHAN);
    assign icb.icb_cmd_addr  = addr_q;
    assign icb.icb_cmd_wdata = wdata_q;
    assign icb.icb_cmd_wmask = wstrb_q;
    assign icb.icb_cmd_read  = (wstrb_q == 4'b0000);

endmodule

// File: tb/tb_mem2icb_bridge.sv
// Directed bench for mem2icb_bridge: vector table of single transfers plus timeout/orphan/reset sequences.
module tb_mem2icb_bridge;
    import mem2icb_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_valid, mem_ready, err_pulse;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, err_addr;
    logic [3:0]  mem_wstrb;

    mem2icb_if bus();

    mem2icb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .icb       (bus),
        .err_pulse (err_pulse),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_err_addr = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cmd_wait;
        int          rsp_wait;
        logic [31:0] rsp_rdata;
        logic        rsp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one CPU access against a reactive slave and checks the completion.
    task automatic run_txn(input vec_t v, input string tag);
        int cyc, cmd_cnt, rsp_cnt;
        bit done, stable;
        mem_valid = 1'b1;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
        cyc = 0; cmd_cnt = 0; rsp_cnt = 0; done = 0; stable = 1;
        while (!done && cyc < 40) begin
            step();
            cyc++;
            if (mem_ready) begin
                done = 1;
                bus.icb_cmd_ready = 1'b0;
                bus.icb_rsp_valid = 1'b0;
            end else begin
                if (bus.icb_cmd_valid) begin
                    if (bus.icb_cmd_addr !== v.addr || bus.icb_cmd_wdata !== v.wdata ||
                        bus.icb_cmd_wmask !== v.wstrb || bus.icb_cmd_read !== (v.wstrb == 4'b0000))
                        stable = 0;
                    bus.icb_cmd_ready = (cmd_cnt >= v.cmd_wait);
                    cmd_cnt++;
                end else begin
                    bus.icb_cmd_ready = 1'b0;
                end
                if (bus.icb_rsp_ready) begin
                    bus.icb_rsp_valid = (rsp_cnt >= v.rsp_wait);
                    bus.icb_rsp_rdata = v.rsp_rdata;
                    bus.icb_rsp_err   = v.rsp_err;
                    rsp_cnt++;
                end else begin
                    bus.icb_rsp_valid = 1'b0;
                end
            end
        end
        if (v.exp_err) exp_err_addr = v.addr;
        check({tag, " latency"}, cyc, v.exp_lat);
        check({tag, " mem_rdata"}, mem_rdata, v.exp_rdata);
        check({tag, " err_pulse"}, err_pulse, v.exp_err);
        check({tag, " err_addr"}, err_addr, exp_err_addr);
        check({tag, " cmd fields stable"}, (stable && cmd_cnt > 0), 1);
        // mem_valid is still high in the ready cycle; it must not start a new access.
        step();
        mem_valid = 1'b0;
        check({tag, " ready one cycle"}, mem_ready, 0);
        step();
        check({tag, " no retrigger"}, bus.icb_cmd_valid, 0);
    endtask

    // Read that the slave accepts but never answers; returns in the mem_ready cycle.
    task automatic start_dead_read(input logic [31:0] addr, input string tag);
        int cyc;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = 32'h0; mem_wstrb = 4'b0000;
        step();
        check({tag, " cmd_valid"}, bus.icb_cmd_valid, 1);
        bus.icb_cmd_ready = 1'b1;
        step();
        bus.icb_cmd_ready = 1'b0;
        cyc = 2;
        while (!mem_ready && cyc < 30) begin
            step();
            cyc++;
        end
        exp_err_addr = addr;
        check({tag, " timeout latency"}, cyc, 10);
        check({tag, " timeout rdata"}, mem_rdata, 32'hFFFF_FFFF);
        check({tag, " timeout err_pulse"}, err_pulse, 1);
        check({tag, " timeout err_addr"}, err_addr, exp_err_addr);
    endtask

    initial begin
        bit seen;
        mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        bus.icb_cmd_ready = 1'b0; bus.icb_rsp_valid = 1'b0;
        bus.icb_rsp_rdata = '0;   bus.icb_rsp_err = 1'b0;

        //                addr          wdata         wstrb    cw   rw  rsp_rdata     err   lat exp_rdata     exp_err
        vecs[0] = '{32'h0020_0004, 32'h0000_0000, 4'b0000,   0,  0, 32'h1234_5678, 1'b0,  3, 32'h1234_5678, 1'b0};
        vecs[1] = '{32'h0020_0008, 32'hA5A5_0000, 4'b1100,   5,  2, 32'hDEAD_BEEF, 1'b0, 10, 32'h0000_0000, 1'b0};
        vecs[2] = '{32'h0040_0010, 32'h0000_0000, 4'b0000,   0,  0, 32'h1111_1111, 1'b1,  3, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{32'h0040_0020, 32'h0000_00C3, 4'b0001,   1,  0, 32'h2222_2222, 1'b1,  4, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{32'h0010_0000, 32'h0000_0000, 4'b0000,   2,  1, 32'h0BAD_F00D, 1'b0,  6, 32'h0BAD_F00D, 1'b0};
        vecs[5] = '{32'h0050_0000, 32'h0000_0000, 4'b0000, 100,  0, 32'h3333_3333, 1'b0, 10, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{32'h0060_0004, 32'h0000_0000, 4'b0000,   8,  0, 32'h7777_0001, 1'b0, 11, 32'h7777_0001, 1'b0};
        vecs[7] = '{32'h0060_0008, 32'h0102_0304, 4'b1111,   0,  0, 32'h9999_9999, 1'b0,  3, 32'h0000_0000, 1'b0};

        // Asynchronous reset
        #2 resetn = 1'b0;
        #10;
        check("rst mem_ready",     mem_ready,         0);
        check("rst mem_rdata",     mem_rdata,         0);
        check("rst cmd_valid",     bus.icb_cmd_valid, 0);
        check("rst rsp_ready",     bus.icb_rsp_ready, 0);
        check("rst err_pulse",     err_pulse,         0);
        check("rst cmd_addr",      bus.icb_cmd_addr,  0);
        check("rst cmd_wdata",     bus.icb_cmd_wdata, 0);
        check("rst cmd_read",      bus.icb_cmd_read,  1);
        check("rst cmd_wmask",     bus.icb_cmd_wmask, 0);
        check("rst err_addr",      err_addr,          0);
        @(negedge clk) resetn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Response timeout, then a late response is swallowed in the orphan drain.
        start_dead_read(32'h0030_0000, "orphan_a");
        seen = 0;
        step();
        mem_valid = 1'b0;
        check("orphan_a rsp_ready", bus.icb_rsp_ready, 1);
        check("orphan_a cmd_valid", bus.icb_cmd_valid, 0);
        seen |= mem_ready;
        step(); seen |= mem_ready;
        step(); seen |= mem_ready;
        bus.icb_rsp_valid = 1'b1; bus.icb_rsp_rdata = 32'h5555_AAAA; bus.icb_rsp_err = 1'b0;
        step(); seen |= mem_ready;
        bus.icb_rsp_valid = 1'b0;
        check("orphan_a drained", bus.icb_rsp_ready, 0);
        step(); seen |= mem_ready;
        step(); seen |= mem_ready;
        check("orphan_a no mem_ready", seen, 0);
        run_txn('{32'h0030_0010, 32'h0, 4'b0000, 0, 0, 32'hCAFE_0001, 1'b0, 3, 32'hCAFE_0001, 1'b0},
                "after_orphan");

        // Orphan exits on its own timer; a request raised meanwhile waits for IDLE.
        start_dead_read(32'h0030_0004, "orphan_b");
        step();                                   // cycle 11
        mem_valid = 1'b0;
        step();                                   // cycle 12
        mem_valid = 1'b1; mem_addr = 32'h0030_0008; mem_wstrb = 4'b0000;
        seen = 0;
        for (int c = 12; c < 20; c++) begin
            if (bus.icb_cmd_valid !== 1'b0 || bus.icb_rsp_ready !== 1'b1 || mem_ready !== 1'b0) seen = 1;
            step();
        end
        check("orphan_b held in drain", seen, 0);
        check("orphan_b exit rsp_ready", bus.icb_rsp_ready, 0);      // cycle 20
        check("orphan_b exit cmd_valid", bus.icb_cmd_valid, 0);
        step();                                                        // cycle 21
        check("orphan_b queued cmd_valid", bus.icb_cmd_valid, 1);
        check("orphan_b queued cmd_addr", bus.icb_cmd_addr, 32'h0030_0008);
        bus.icb_cmd_ready = 1'b1;
        step();
        bus.icb_cmd_ready = 1'b0;
        bus.icb_rsp_valid = 1'b1; bus.icb_rsp_rdata = 32'h0C0F_FEE0; bus.icb_rsp_err = 1'b0;
        step();
        bus.icb_rsp_valid = 1'b0;
        check("orphan_b queued ready", mem_ready, 1);
        check("orphan_b queued rdata", mem_rdata, 32'h0C0F_FEE0);
        check("orphan_b queued err", err_pulse, 0);
        step();
        mem_valid = 1'b0;
        step();

        // Reset while waiting for a response; the late response must be ignored.
        mem_valid = 1'b1; mem_addr = 32'h0070_0000; mem_wstrb = 4'b0000;
        step();
        bus.icb_cmd_ready = 1'b1;
        step();
        bus.icb_cmd_ready = 1'b0;
        check("midrst in RSP", bus.icb_rsp_ready, 1);
        step();
        #2 resetn = 1'b0;
        mem_valid = 1'b0;
        #1;
        exp_err_addr = 32'h0;
        check("midrst rsp_ready", bus.icb_rsp_ready, 0);
        check("midrst cmd_valid", bus.icb_cmd_valid, 0);
        check("midrst cmd_addr",  bus.icb_cmd_addr,  0);
        check("midrst cmd_read",  bus.icb_cmd_read,  1);
        check("midrst err_addr",  err_addr,          exp_err_addr);
        check("midrst mem_rdata", mem_rdata,         0);
        @(negedge clk) resetn = 1'b1;
        bus.icb_rsp_valid = 1'b1; bus.icb_rsp_rdata = 32'h4444_4444;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (mem_ready !== 1'b0 || bus.icb_rsp_ready !== 1'b0) seen = 1;
        end
        bus.icb_rsp_valid = 1'b0;
        check("midrst late rsp ignored", seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
